// File: rtl/regbank_write_scheduler.sv
// Arbitrates the register bank's single write port between the ALU and load writeback
// paths and keeps the busy scoreboard for decode. Optional macro: RB_WB_FWD_EN.
module regbank_write_scheduler #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [AW-1:0]     alu_rd,
   input  logic [DW-1:0]     alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [AW-1:0]     mem_rd,
   input  logic [DW-1:0]     mem_data,
   output logic              mem_ready,
   output logic              wrReg,
   output logic [AW-1:0]     rd,
   output logic [DW-1:0]     rdIn,
   input  logic              rsv_en,
   input  logic [AW-1:0]     rsv_rd,
   input  logic [AW-1:0]     rs,
   input  logic [AW-1:0]     rt,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic              stall,
   output logic [2**AW-1:0]  busy_vec
);

   localparam int NR = 2**AW;

   logic [1:0]          holdV_q, holdV_d;
   logic [1:0][AW-1:0]  holdRd_q, holdRd_d;
   logic [1:0][DW-1:0]  holdData_q, holdData_d;
   logic                rrPtr_q, rrPtr_d;
   logic [NR-1:0]       busy_q, busy_d;

   logic [1:0]          grant;
   logic [1:0]          accept;
   logic [1:0][AW-1:0]  reqRd;
   logic [1:0][DW-1:0]  reqData;
   logic                rsRaw, rtRaw;

   assign reqRd[0]   = alu_rd;
   assign reqRd[1]   = mem_rd;
   assign reqData[0] = alu_data;
   assign reqData[1] = mem_data;

   // The round-robin pointer only matters when both holding registers are occupied.
   always_comb begin
      grant = holdV_q;
      if (&holdV_q) begin
         grant = rrPtr_q ? 2'b10 : 2'b01;
      end
   end

   assign alu_ready = !rst && (!holdV_q[0] || grant[0]);
   assign mem_ready = !rst && (!holdV_q[1] || grant[1]);
   assign accept    = {mem_valid && mem_ready, alu_valid && alu_ready};

   assign wrReg = |holdV_q;
   assign rd    = grant[1] ? holdRd_q[1]   : (grant[0] ? holdRd_q[0]   : '0);
   assign rdIn  = grant[1] ? holdData_q[1] : (grant[0] ? holdData_q[0] : '0);

   // Writes to r0 complete the handshake but never occupy a holding register.
   always_comb begin
      holdV_d    = holdV_q & ~grant;
      holdRd_d   = holdRd_q;
      holdData_d = holdData_q;
      for (int i = 0; i < 2; i++) begin
         if (accept[i] && (reqRd[i] != '0)) begin
            holdV_d[i]    = 1'b1;
            holdRd_d[i]   = reqRd[i];
            holdData_d[i] = reqData[i];
         end
      end
      rrPtr_d = (&holdV_q) ? ~rrPtr_q : rrPtr_q;
   end

   // A reservation landing on the same edge as the write to that register must win.
   always_comb begin
      busy_d = busy_q;
      if (wrReg) begin
         busy_d[rd] = 1'b0;
      end
      if (rsv_en && (rsv_rd != '0)) begin
         busy_d[rsv_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdV_q    <= '0;
         holdRd_q   <= '0;
         holdData_q <= '0;
         rrPtr_q    <= 1'b0;
         busy_q     <= '0;
      end else begin
         holdV_q    <= holdV_d;
         holdRd_q   <= holdRd_d;
         holdData_q <= holdData_d;
         rrPtr_q    <= rrPtr_d;
         busy_q     <= busy_d;
      end
   end

   assign rsRaw = busy_q[rs];
   assign rtRaw = busy_q[rt];

`ifdef RB_WB_FWD_EN
   // The bank commits on the negedge, so a register being written this cycle is readable.
   assign rs_busy = rsRaw && !(wrReg && (rd == rs) && (rs != '0));
   assign rt_busy = rtRaw && !(wrReg && (rd == rt) && (rt != '0));
`else
   assign rs_busy = rsRaw;
   assign rt_busy = rtRaw;
`endif

   assign stall    = rs_busy | rt_busy;
   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Directed bench for regbank_write_scheduler: a queue-level model checked every negedge,
// plus literal expectations for the key scenarios.
module tb_regbank_write_scheduler;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, mem_valid, rsv_en;
   logic [AW-1:0] alu_rd, mem_rd, rsv_rd, rs, rt;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_ready, mem_ready, wrReg, rs_busy, rt_busy, stall;
   logic [AW-1:0] rd;
   logic [DW-1:0] rdIn;
   logic [31:0]   busy_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regbank_write_scheduler #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .wrReg(wrReg), .rd(rd), .rdIn(rdIn),
      .rsv_en(rsv_en), .rsv_rd(rsv_rd), .rs(rs), .rt(rt),
      .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall), .busy_vec(busy_vec)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Model: each requester has at most one pending write; mFavour says who goes first
   // when both are pending; mBusy is the set of reserved registers.
   bit          mPend [2];
   int          mDest [2];
   logic [31:0] mVal  [2];
   int          mFavour;
   bit          mBusy [32];

   function automatic int winner();
      if (mPend[0] && mPend[1]) return mFavour;
      if (mPend[0]) return 0;
      if (mPend[1]) return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin : modelUpdate
      int w;
      bit rdyA, rdyM;
      if (rst) begin
         mPend[0] = 0; mPend[1] = 0;
         mFavour = 0;
         for (int i = 0; i < 32; i++) mBusy[i] = 0;
      end else begin
         w = winner();
         rdyA = !mPend[0] || (w == 0);
         rdyM = !mPend[1] || (w == 1);
         if (w >= 0) mBusy[mDest[w]] = 0;
         if (rsv_en && rsv_rd != 0) mBusy[rsv_rd] = 1;
         if (mPend[0] && mPend[1]) mFavour = 1 - w;
         if (w >= 0) mPend[w] = 0;
         if (alu_valid && rdyA && alu_rd != 0) begin
            mPend[0] = 1; mDest[0] = int'(alu_rd); mVal[0] = alu_data;
         end
         if (mem_valid && rdyM && mem_rd != 0) begin
            mPend[1] = 1; mDest[1] = int'(mem_rd); mVal[1] = mem_data;
         end
      end
   end

   always @(negedge clk) begin : compareModel
      int w;
      logic [AW-1:0] expRd;
      logic [31:0] expData, expBusy;
      bit expRs, expRt;
      if (!rst) begin
         w = winner();
         expRd = '0;
         expData = '0;
         if (w >= 0) begin
            expRd = AW'(mDest[w]);
            expData = mVal[w];
         end
         for (int i = 0; i < 32; i++) expBusy[i] = mBusy[i];
         expRs = mBusy[rs];
         expRt = mBusy[rt];
`ifdef RB_WB_FWD_EN
         if (w >= 0 && rs != 0 && mDest[w] == int'(rs)) expRs = 0;
         if (w >= 0 && rt != 0 && mDest[w] == int'(rt)) expRt = 0;
`endif
         checkOutput("wrReg", 64'(wrReg), 64'(w >= 0));
         checkOutput("rd", 64'(rd), 64'(expRd));
         checkOutput("rdIn", 64'(rdIn), 64'(expData));
         checkOutput("alu_ready", 64'(alu_ready), 64'(!mPend[0] || w == 0));
         checkOutput("mem_ready", 64'(mem_ready), 64'(!mPend[1] || w == 1));
         checkOutput("busy_vec", 64'(busy_vec), 64'(expBusy));
         checkOutput("rs_busy", 64'(rs_busy), 64'(expRs));
         checkOutput("rt_busy", 64'(rt_busy), 64'(expRt));
         checkOutput("stall", 64'(stall), 64'(expRs | expRt));
      end
   end

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      mem_valid = 0; mem_rd = '0; mem_data = '0;
      rsv_en = 0; rsv_rd = '0; rs = '0; rt = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_wrReg", 64'(wrReg), 64'd0);
      checkOutput("reset_busy", 64'(busy_vec), 64'd0);
      checkOutput("reset_readys", 64'({alu_ready, mem_ready}), 64'b11);

      // ALU alone: accepted at edge N, written during cycle N+1
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      applyStimulus();
      alu_valid = 0;
      @(negedge clk);
      checkOutput("alu_wrReg", 64'(wrReg), 64'd1);
      checkOutput("alu_rd", 64'(rd), 64'd5);
      checkOutput("alu_rdIn", 64'(rdIn), 64'hDEADBEEF);
      applyStimulus();
      @(negedge clk);
      checkOutput("alu_idle", 64'(wrReg), 64'd0);

      // Contention twice: ALU wins first, MEM wins the rematch
      for (int round = 0; round < 2; round++) begin
         alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
         mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h22;
         applyStimulus();
         alu_valid = 0; mem_valid = 0;
         @(negedge clk);
         checkOutput("cont_first_rd", 64'(rd), (round == 0) ? 64'd3 : 64'd4);
         checkOutput("cont_first_data", 64'(rdIn), (round == 0) ? 64'h11 : 64'h22);
         checkOutput("cont_readys", 64'({alu_ready, mem_ready}), (round == 0) ? 64'b10 : 64'b01);
         applyStimulus();
         @(negedge clk);
         checkOutput("cont_second_rd", 64'(rd), (round == 0) ? 64'd4 : 64'd3);
         applyStimulus();
      end

      // r0 writes are swallowed
      mem_valid = 1; mem_rd = 5'd0; mem_data = 32'hFF;
      @(negedge clk);
      checkOutput("r0_ready", 64'(mem_ready), 64'd1);
      applyStimulus();
      mem_valid = 0;
      @(negedge clk);
      checkOutput("r0_wrReg", 64'(wrReg), 64'd0);
      checkOutput("r0_busy", 64'(busy_vec), 64'd0);

      // Back-to-back ALU writes, one per cycle
      for (int i = 1; i <= 3; i++) begin
         alu_valid = 1; alu_rd = AW'(i); alu_data = 32'(i * 16);
         applyStimulus();
      end
      alu_valid = 0;
      @(negedge clk);
      checkOutput("b2b_rd", 64'(rd), 64'd3);
      checkOutput("b2b_rdIn", 64'(rdIn), 64'h30);

      // Scoreboard stall on r7 released by the ALU write
      rsv_en = 1; rsv_rd = 5'd7; rs = 5'd7;
      applyStimulus();
      rsv_en = 0;
      @(negedge clk);
      checkOutput("sb_stall", 64'(stall), 64'd1);
      applyStimulus();
      @(negedge clk);
      checkOutput("sb_stall_hold", 64'(stall), 64'd1);
      alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
      applyStimulus();
      alu_valid = 0;
      @(negedge clk);
`ifdef RB_WB_FWD_EN
      checkOutput("sb_stall_wr", 64'(stall), 64'd0);
`else
      checkOutput("sb_stall_wr", 64'(stall), 64'd1);
`endif
      applyStimulus();
      @(negedge clk);
      checkOutput("sb_stall_after", 64'(stall), 64'd0);
      rs = '0;

      // Reservation and write of r9 on the same edge: reservation survives
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
      applyStimulus();
      alu_valid = 0; rsv_en = 1; rsv_rd = 5'd9; rt = 5'd9;
      applyStimulus();
      rsv_en = 0;
      @(negedge clk);
      checkOutput("coll_busy9", 64'(busy_vec[9]), 64'd1);
      checkOutput("coll_rt_busy", 64'(rt_busy), 64'd1);

      // Mixed traffic patterns across both requesters
      for (int i = 0; i < 12; i++) begin
         alu_valid = i[0]; alu_rd = AW'(i + 1); alu_data = 32'(i * 3);
         mem_valid = i[1] | i[2]; mem_rd = AW'(i + 16); mem_data = 32'(i * 5);
         rsv_en = i[3]; rsv_rd = AW'(i + 8); rs = AW'(i + 1); rt = AW'(i + 16);
         applyStimulus();
      end
      alu_valid = 0; mem_valid = 0; rsv_en = 0;

      // Reset while both holding registers are full
      alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hA;
      mem_valid = 1; mem_rd = 5'd11; mem_data = 32'hB;
      rsv_en = 1; rsv_rd = 5'd12;
      applyStimulus();
      alu_valid = 0; mem_valid = 0; rsv_en = 0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_wrReg", 64'(wrReg), 64'd0);
      checkOutput("rst_rd", 64'(rd), 64'd0);
      checkOutput("rst_rdIn", 64'(rdIn), 64'd0);
      checkOutput("rst_busy", 64'(busy_vec), 64'd0);
      checkOutput("rst_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_readys", 64'({alu_ready, mem_ready}), 64'b11);
      checkOutput("rst_idle", 64'(wrReg), 64'd0);
      repeat (2) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
